// File: rtl/tilemap_write_arbiter.sv
// Shares the tilemap write port between CPU stores (priority) and a rectangle-fill engine.
// Optional TILEMAP_FILL_WORD_EN: fill writes a whole aligned word when 4+ tiles remain in the row.
module tilemap_write_arbiter #(
    parameter int MAP_WIDTH    = 40,
    parameter int MAP_HEIGHT   = 30,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_cpu_wdata,
    input  logic        i_cpu_wea,
    input  logic [3:0]  i_cpu_wselect,
    input  logic [26:0] i_cpu_waddr,
    output logic        o_cpu_stall,
    input  logic        i_fill_start,
    input  logic [5:0]  i_fill_x0,
    input  logic [5:0]  i_fill_y0,
    input  logic [5:0]  i_fill_w,
    input  logic [5:0]  i_fill_h,
    input  logic [7:0]  i_fill_value,
    output logic        o_fill_busy,
    output logic        o_fill_done,
    output logic [31:0] o_wdata,
    output logic        o_wea,
    output logic [3:0]  o_wselect,
    output logic [26:0] o_waddr
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [6:0] MW7 = 7'(MAP_WIDTH);
    localparam logic [6:0] MH7 = 7'(MAP_HEIGHT);

`ifdef TILEMAP_FILL_WORD_EN
    if (MAP_WIDTH % 4 != 0) begin : g_bad_width
        $error("TILEMAP_FILL_WORD_EN requires MAP_WIDTH to be a multiple of 4");
    end
`endif

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t          state_q;
    logic [6:0]      x0_q, x_q, y_q, x_end_q, y_end_q;
    logic [7:0]      value_q;
    logic            empty_q;
    logic [SW-1:0]   starve_q;
    logic [31:0]     wdata_q;
    logic            wea_q;
    logic [3:0]      wsel_q;
    logic [26:0]     waddr_q;

    logic            fill_active, stall, grant_fill, grant_cpu;
    logic [26:0]     fill_addr;
    logic [3:0]      fill_sel;
    logic [6:0]      step, x_next, y_next, sum_x, sum_y, x_end_d, y_end_d;
    logic            row_end, last_tile, start_empty;

    always_comb begin
        fill_active = (state_q == S_FILL) && !empty_q;
        stall       = (state_q == S_FILL) && (starve_q == SW'(STARVE_LIMIT));
        grant_fill  = fill_active && (stall || !i_cpu_wea);
        grant_cpu   = !stall && i_cpu_wea;

        fill_addr = 27'(y_q) * 27'(MAP_WIDTH) + 27'(x_q);
        step      = 7'd1;
        fill_sel  = 4'b0001 << fill_addr[1:0];
`ifdef TILEMAP_FILL_WORD_EN
        if (fill_addr[1:0] == 2'b00 && (x_end_q - x_q) >= 7'd4) begin
            step     = 7'd4;
            fill_sel = 4'hF;
        end
`endif
        x_next    = x_q + step;
        y_next    = y_q + 7'd1;
        row_end   = x_next >= x_end_q;
        last_tile = row_end && (y_next >= y_end_q);

        // 7-bit sums cannot overflow 6-bit operands, so clipping is a plain compare.
        sum_x       = {1'b0, i_fill_x0} + {1'b0, i_fill_w};
        sum_y       = {1'b0, i_fill_y0} + {1'b0, i_fill_h};
        x_end_d     = (sum_x > MW7) ? MW7 : sum_x;
        y_end_d     = (sum_y > MH7) ? MH7 : sum_y;
        start_empty = (i_fill_w == 6'd0) || (i_fill_h == 6'd0) ||
                      ({1'b0, i_fill_x0} >= MW7) || ({1'b0, i_fill_y0} >= MH7);
    end

    // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
            value_q  <= '0;
            empty_q  <= 1'b0;
            starve_q <= '0;
            wdata_q  <= '0;
            wea_q    <= 1'b0;
            wsel_q   <= '0;
            waddr_q  <= '0;
        end else begin
            wea_q <= grant_fill || grant_cpu;
            if (grant_fill) begin
                waddr_q <= {fill_addr[26:2], 2'b00};
                wsel_q  <= fill_sel;
                wdata_q <= {4{value_q}};
            end else if (grant_cpu) begin
                waddr_q <= i_cpu_waddr;
                wsel_q  <= i_cpu_wselect;
                wdata_q <= i_cpu_wdata;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_fill_start) begin
                        x0_q     <= {1'b0, i_fill_x0};
                        x_q      <= {1'b0, i_fill_x0};
                        y_q      <= {1'b0, i_fill_y0};
                        x_end_q  <= x_end_d;
                        y_end_q  <= y_end_d;
                        value_q  <= i_fill_value;
                        empty_q  <= start_empty;
                        starve_q <= '0;
                        state_q  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (empty_q) begin
                        state_q <= S_DONE;
                    end else if (grant_fill) begin
                        starve_q <= '0;
                        if (last_tile) begin
                            state_q <= S_DONE;
                        end else if (row_end) begin
                            x_q <= x0_q;
                            y_q <= y_next;
                        end else begin
                            x_q <= x_next;
                        end
                    end else if (grant_cpu) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_stall = stall;
    assign o_fill_busy = (state_q == S_FILL);
    assign o_fill_done = (state_q == S_DONE);
    assign o_wdata     = wdata_q;
    assign o_wea       = wea_q;
    assign o_wselect   = wsel_q;
    assign o_waddr     = waddr_q;

endmodule
